updi_frame_builder: RTL and testbench
=====================================

UPDI_FRAME_BUILDER -- requirements
Module: updi_frame_builder

Interface
REQ-001 Parameter MAX_ADDR_BYTES, default 3: widest address operand supported (2 or 3).
REQ-002 Parameter KEY_BYTES_MAX, default 16: widest KEY payload (8 or 16).
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 cmd_valid / cmd_ready  input / output  1 / 1  command handshake.
REQ-006 cmd_instr  input  3  updi_instr_t (LDS, LD, STS, ST, LDCS, REPEAT, STCS, KEY).
REQ-007 cmd_size_a, cmd_size_b, cmd_ptr, cmd_size_c  input  2 each  opcode fields.
REQ-008 cmd_cs_addr  input  4  control/status register address.
REQ-009 cmd_sib  input  1  KEY SIB select.
REQ-010 cmd_addr  input  8*MAX_ADDR_BYTES  address operand, little-endian.
REQ-011 cmd_data  input  16  ST/STS/STCS/REPEAT data operand, little-endian.
REQ-012 cmd_key  input  8*KEY_BYTES_MAX  KEY payload, byte 0 sent first.
REQ-013 tx_data / tx_valid / tx_ready  output / output / input  8 / 1 / 1  outbound byte stream.
REQ-014 ack_valid, ack_ok  input  1 each  STS ACK report from receiver (0x40 seen = ack_ok high).
REQ-015 busy, cmd_err, ack_err  output  1 each  status; errors are one-cycle pulses.

Function
REQ-016 Command accepted on cycle with cmd_valid & cmd_ready; cmd_ready high only in IDLE; all cmd_* fields registered at acceptance.
REQ-017 States: IDLE, SYNC, OPCODE, ADDR, WAIT_ACK, DATA; next state taken only on tx_valid & tx_ready (except WAIT_ACK).
REQ-018 Frame = 0x55, opcode, then operands: LDS addr; LD none; STS addr, WAIT_ACK, data; ST data; LDCS none; REPEAT 1 byte; STCS 1 byte; KEY key bytes.
REQ-019 Opcode = {instr[2:0], then per instruction: LDS/STS 0,size_a,size_b; LD/ST 0,ptr,size_a; LDCS/STCS 0,cs_addr; REPEAT 000,size_b; KEY 00,sib,size_c}.
REQ-020 Address byte count = size_a+1; data byte count (ST/STS) = size_b+1 for STS, size_a+1 for ST; KEY count = 8 << size_c.
REQ-021 Reserved encodings (size code 3, address bytes > MAX_ADDR_BYTES, data size code > 1, KEY bytes > KEY_BYTES_MAX, REPEAT size_b != 0) -> cmd_err pulse cycle after acceptance, no bytes emitted, return to IDLE.
REQ-022 tx_valid high in SYNC/OPCODE/ADDR/DATA; tx_data stable while tx_valid & !tx_ready.
REQ-023 Byte counter decrements per accepted byte; last byte of a segment advances state in same cycle; back-to-back bytes with no bubble when tx_ready held high.
REQ-024 WAIT_ACK: tx_valid low; ack_valid & ack_ok -> DATA; ack_valid & !ack_ok -> ack_err pulse, IDLE; no timeout inside block.
REQ-025 Frame end: last accepted byte -> IDLE next cycle; cmd_ready high that cycle (one-cycle turnaround).
REQ-026 busy = state != IDLE.
REQ-027 ack_valid outside WAIT_ACK ignored.

Reset
REQ-028 rst_n low at any time, including mid-frame, forces IDLE asynchronously; tx_valid=0, tx_data=0x00, cmd_ready=0 while in reset, busy=0, cmd_err=0, ack_err=0, counters and registered command cleared.
REQ-029 cmd_ready rises the first clock edge after rst_n deasserts; partial frame never resumed.

Structure
REQ-030 Package updi_pkg holds updi_instr_t enum, UPDI_SYNC (0x55), UPDI_ACK (0x40), size-code constants.
REQ-031 Opcode formation in one combinational sub-module updi_opcode_encode (instr + fields -> 8-bit opcode); builder instantiates it once on the registered command.

Verification
REQ-032 LDS size_a=1 addr 0x1234, tx_ready=1 -> bytes 55,04,34,12 on 4 consecutive cycles, then cmd_ready.
REQ-033 STS size_a=0 size_b=1 addr 0x0F data 0xBEEF, ack_ok pulse after 5 cycles -> 55,41,0F, tx_valid low until ack, then EF,BE.
REQ-034 STS with ack_valid & !ack_ok -> ack_err one pulse, no data bytes, IDLE.
REQ-035 KEY size_c=0 sib=0 -> 55,E0, 8 key bytes in order; tx_ready random toggling -> same sequence, tx_data held during stalls.
REQ-036 LDS size_a=3 -> cmd_err pulse, zero bytes; STCS cs_addr=3 data 0x08 -> 55,C3,08.
REQ-037 rst_n low during ADDR of LDS -> tx_valid 0 immediately; after release, new LDCS cs_addr=0 -> 55,80.

Source files
------------

// File: rtl/updi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// updi_pkg : shared UPDI instruction, state and constant definitions
// Revision 1.0
// ---------------------------------------------------------------------------
package updi_pkg;

    typedef enum logic [2:0] {
        INSTR_LDS    = 3'd0,
        INSTR_LD     = 3'd1,
        INSTR_STS    = 3'd2,
        INSTR_ST     = 3'd3,
        INSTR_LDCS   = 3'd4,
        INSTR_REPEAT = 3'd5,
        INSTR_STCS   = 3'd6,
        INSTR_KEY    = 3'd7
    } updi_instr_t;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SYNC     = 3'd1,
        S_OPCODE   = 3'd2,
        S_ADDR     = 3'd3,
        S_WAIT_ACK = 3'd4,
        S_DATA     = 3'd5
    } updi_state_t;

    typedef struct packed {
        updi_instr_t instr;
        logic [1:0]  size_a;
        logic [1:0]  size_b;
        logic [1:0]  ptr;
        logic [1:0]  size_c;
        logic [3:0]  cs_addr;
        logic        sib;
    } updi_cmd_t;

    localparam logic [7:0] UPDI_SYNC = 8'h55;
    localparam logic [7:0] UPDI_ACK  = 8'h40;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_WORD = 2'd1;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

endpackage
`default_nettype wire

// File: rtl/updi_opcode_encode.sv
`default_nettype none
// ---------------------------------------------------------------------------
// updi_opcode_encode : builds the 8-bit UPDI opcode from instruction fields
// Revision 1.0
// ---------------------------------------------------------------------------
module updi_opcode_encode
    import updi_pkg::*;
(
    input  updi_instr_t i_instr,
    input  logic [1:0]  i_size_a,
    input  logic [1:0]  i_size_b,
    input  logic [1:0]  i_ptr,
    input  logic [1:0]  i_size_c,
    input  logic [3:0]  i_cs_addr,
    input  logic        i_sib,
    output logic [7:0]  o_opcode
);

    always_comb begin
        o_opcode = {i_instr, 5'b00000};
        case (i_instr)
            INSTR_LDS, INSTR_STS:   o_opcode[4:0] = {1'b0, i_size_a, i_size_b};
            INSTR_LD, INSTR_ST:     o_opcode[4:0] = {1'b0, i_ptr, i_size_a};
            INSTR_LDCS, INSTR_STCS: o_opcode[4:0] = {1'b0, i_cs_addr};
            INSTR_REPEAT:           o_opcode[4:0] = {3'b000, i_size_b};
            INSTR_KEY:              o_opcode[4:0] = {2'b00, i_sib, i_size_c};
            default:                o_opcode[4:0] = 5'b00000;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/updi_frame_builder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// updi_frame_builder : serialises one UPDI command into SYNC/opcode/operands
// Revision 1.0
// ---------------------------------------------------------------------------
module updi_frame_builder
    import updi_pkg::*;
#(
    parameter int MAX_ADDR_BYTES = 3,
    parameter int KEY_BYTES_MAX  = 16
)
(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  updi_instr_t                 cmd_instr,
    input  logic [1:0]                  cmd_size_a,
    input  logic [1:0]                  cmd_size_b,
    input  logic [1:0]                  cmd_ptr,
    input  logic [1:0]                  cmd_size_c,
    input  logic [3:0]                  cmd_cs_addr,
    input  logic                        cmd_sib,
    input  logic [8*MAX_ADDR_BYTES-1:0] cmd_addr,
    input  logic [15:0]                 cmd_data,
    input  logic [8*KEY_BYTES_MAX-1:0]  cmd_key,
    output logic [7:0]                  tx_data,
    output logic                        tx_valid,
    input  logic                        tx_ready,
    input  logic                        ack_valid,
    input  logic                        ack_ok,
    output logic                        busy,
    output logic                        cmd_err,
    output logic                        ack_err
);

    localparam int SH_BYTES = (KEY_BYTES_MAX > MAX_ADDR_BYTES) ? KEY_BYTES_MAX : MAX_ADDR_BYTES;
    localparam int SH_W     = 8 * SH_BYTES;
    localparam int CNT_W    = $clog2(SH_BYTES) + 1;

    updi_state_t                 state_q, state_d;
    updi_cmd_t                   cmd_q, cmd_d;
    logic [8*MAX_ADDR_BYTES-1:0] addr_q, addr_d;
    logic [15:0]                 data_q, data_d;
    logic [8*KEY_BYTES_MAX-1:0]  key_q, key_d;
    logic [SH_W-1:0]             sh_q, sh_d;
    logic [CNT_W-1:0]            cnt_q, cnt_d;
    logic                        cmd_err_q, cmd_err_d;
    logic                        ack_err_q, ack_err_d;
    logic                        ready_en_q;

    logic [7:0]       w_opcode;
    logic             w_fire;
    logic             w_cmd_bad;
    logic [CNT_W-1:0] w_data_m1;
    logic [SH_W-1:0]  w_payload;

    updi_opcode_encode u_opcode_encode (
        .i_instr   (cmd_q.instr),
        .i_size_a  (cmd_q.size_a),
        .i_size_b  (cmd_q.size_b),
        .i_ptr     (cmd_q.ptr),
        .i_size_c  (cmd_q.size_c),
        .i_cs_addr (cmd_q.cs_addr),
        .i_sib     (cmd_q.sib),
        .o_opcode  (w_opcode)
    );

    // Reserved encodings are judged on the live inputs so the frame never starts.
    always_comb begin
        w_cmd_bad = 1'b0;
        case (cmd_instr)
            INSTR_LDS, INSTR_STS: w_cmd_bad = (cmd_size_a == SIZE_RSVD)
                                           || (int'(cmd_size_a) >= MAX_ADDR_BYTES)
                                           || (cmd_size_b > SIZE_WORD);
            INSTR_LD, INSTR_ST:   w_cmd_bad = (cmd_size_a > SIZE_WORD);
            INSTR_REPEAT:         w_cmd_bad = (cmd_size_b != SIZE_BYTE);
            INSTR_KEY:            w_cmd_bad = (cmd_size_c == SIZE_RSVD)
                                           || (int'(32'd8 << cmd_size_c) > KEY_BYTES_MAX);
            default:              w_cmd_bad = 1'b0;
        endcase
    end

    always_comb begin
        w_data_m1 = '0;
        w_payload = SH_W'(data_q);
        case (cmd_q.instr)
            INSTR_STS: w_data_m1 = CNT_W'(cmd_q.size_b);
            INSTR_ST:  w_data_m1 = CNT_W'(cmd_q.size_a);
            INSTR_KEY: begin
                w_data_m1 = CNT_W'((32'd8 << cmd_q.size_c) - 32'd1);
                w_payload = SH_W'(key_q);
            end
            default:   w_data_m1 = '0;
        endcase
    end

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        case (state_q)
            S_SYNC:         begin tx_valid = 1'b1; tx_data = UPDI_SYNC; end
            S_OPCODE:       begin tx_valid = 1'b1; tx_data = w_opcode;  end
            S_ADDR, S_DATA: begin tx_valid = 1'b1; tx_data = sh_q[7:0]; end
            default:        begin tx_valid = 1'b0; tx_data = 8'h00;     end
        endcase
    end

    assign w_fire    = tx_valid & tx_ready;
    assign cmd_ready = ready_en_q & (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign cmd_err   = cmd_err_q;
    assign ack_err   = ack_err_q;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        data_d    = data_q;
        key_d     = key_q;
        sh_d      = sh_q;
        cnt_d     = cnt_q;
        cmd_err_d = 1'b0;
        ack_err_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d  = '{instr: cmd_instr, size_a: cmd_size_a, size_b: cmd_size_b,
                              ptr: cmd_ptr, size_c: cmd_size_c, cs_addr: cmd_cs_addr,
                              sib: cmd_sib};
                    addr_d = cmd_addr;
                    data_d = cmd_data;
                    key_d  = cmd_key;
                    if (w_cmd_bad) cmd_err_d = 1'b1;
                    else           state_d   = S_SYNC;
                end
            end
            S_SYNC: begin
                if (w_fire) state_d = S_OPCODE;
            end
            S_OPCODE: begin
                if (w_fire) begin
                    case (cmd_q.instr)
                        INSTR_LDS, INSTR_STS: begin
                            state_d = S_ADDR;
                            cnt_d   = CNT_W'(cmd_q.size_a);
                            sh_d    = SH_W'(addr_q);
                        end
                        INSTR_LD, INSTR_LDCS: state_d = S_IDLE;
                        default: begin
                            state_d = S_DATA;
                            cnt_d   = w_data_m1;
                            sh_d    = w_payload;
                        end
                    endcase
                end
            end
            S_ADDR: begin
                if (w_fire) begin
                    if (cnt_q == '0) begin
                        state_d = (cmd_q.instr == INSTR_STS) ? S_WAIT_ACK : S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        sh_d  = sh_q >> 8;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (ack_valid) begin
                    if (ack_ok) begin
                        state_d = S_DATA;
                        cnt_d   = w_data_m1;
                        sh_d    = w_payload;
                    end else begin
                        ack_err_d = 1'b1;
                        state_d   = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_fire) begin
                    if (cnt_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                        sh_d  = sh_q >> 8;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ready_en_q keeps cmd_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cmd_q      <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            key_q      <= '0;
            sh_q       <= '0;
            cnt_q      <= '0;
            cmd_err_q  <= 1'b0;
            ack_err_q  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            key_q      <= key_d;
            sh_q       <= sh_d;
            cnt_q      <= cnt_d;
            cmd_err_q  <= cmd_err_d;
            ack_err_q  <= ack_err_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_updi_frame_builder.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_updi_frame_builder : directed self-checking bench with a frame model
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_updi_frame_builder;
    import updi_pkg::*;

    localparam int MAB = 3;
    localparam int KBM = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    updi_instr_t  cmd_instr = INSTR_LDS;
    logic [1:0]   cmd_size_a = '0, cmd_size_b = '0, cmd_ptr = '0, cmd_size_c = '0;
    logic [3:0]   cmd_cs_addr = '0;
    logic         cmd_sib = 1'b0;
    logic [23:0]  cmd_addr = '0;
    logic [15:0]  cmd_data = '0;
    logic [127:0] cmd_key = '0;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic         ack_valid = 1'b0, ack_ok = 1'b0;
    logic         busy, cmd_err, ack_err;

    int           checks = 0;
    int           failures = 0;
    logic [7:0]   exp_q[$];
    logic [7:0]   got_q[$];
    logic [7:0]   lit_q[$];
    bit           rand_ready = 1'b0;
    bit           prev_stall = 1'b0;
    logic [7:0]   prev_data = 8'h00;
    logic [7:0]   e_byte;

    updi_frame_builder #(.MAX_ADDR_BYTES(MAB), .KEY_BYTES_MAX(KBM)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_instr(cmd_instr), .cmd_size_a(cmd_size_a), .cmd_size_b(cmd_size_b),
        .cmd_ptr(cmd_ptr), .cmd_size_c(cmd_size_c), .cmd_cs_addr(cmd_cs_addr),
        .cmd_sib(cmd_sib), .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_key(cmd_key),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .ack_valid(ack_valid), .ack_ok(ack_ok),
        .busy(busy), .cmd_err(cmd_err), .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    // Every accepted byte is checked against the model queue; stalls must hold data.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                checks++;
                if (!(tx_valid === 1'b1 && tx_data === prev_data)) begin
                    failures++;
                    $display("FAIL stall_hold: got valid=%0b data=%02h required valid=1 data=%02h",
                             tx_valid, tx_data, prev_data);
                end
            end
            if (tx_valid && tx_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_byte: got %02h required no byte", tx_data);
                end else begin
                    e_byte = exp_q.pop_front();
                    if (tx_data !== e_byte) begin
                        failures++;
                        $display("FAIL tx_byte: got %02h required %02h", tx_data, e_byte);
                    end
                end
                got_q.push_back(tx_data);
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Frame model: returns 1 for a reserved encoding, else queues the expected bytes.
    function automatic bit model_frame(input updi_instr_t ins, input logic [1:0] sa, sb, ptr, sc,
                                       input logic [3:0] cs, input logic sib,
                                       input logic [23:0] addr, input logic [15:0] data,
                                       input logic [127:0] key, input bit ackok,
                                       output int pre_ack);
        int op;
        pre_ack = 0;
        case (ins)
            INSTR_LDS, INSTR_STS: if (sa == 3 || int'(sa) + 1 > MAB || sb > 1) return 1'b1;
            INSTR_LD, INSTR_ST:   if (sa > 1) return 1'b1;
            INSTR_REPEAT:         if (sb != 0) return 1'b1;
            INSTR_KEY:            if (sc == 3 || (8 << sc) > KBM) return 1'b1;
            default:              ;
        endcase
        op = int'(ins) * 32;
        case (ins)
            INSTR_LDS, INSTR_STS:   op += int'(sa) * 4 + int'(sb);
            INSTR_LD, INSTR_ST:     op += int'(ptr) * 4 + int'(sa);
            INSTR_LDCS, INSTR_STCS: op += int'(cs);
            INSTR_REPEAT:           op += int'(sb);
            default:                op += int'(sib) * 4 + int'(sc);
        endcase
        exp_q.push_back(8'h55);
        exp_q.push_back(8'(op));
        case (ins)
            INSTR_LDS: for (int i = 0; i <= int'(sa); i++) exp_q.push_back(addr[8*i +: 8]);
            INSTR_STS: begin
                for (int i = 0; i <= int'(sa); i++) exp_q.push_back(addr[8*i +: 8]);
                pre_ack = int'(sa) + 3;
                if (ackok) for (int i = 0; i <= int'(sb); i++) exp_q.push_back(data[8*i +: 8]);
            end
            INSTR_ST: for (int i = 0; i <= int'(sa); i++) exp_q.push_back(data[8*i +: 8]);
            INSTR_REPEAT, INSTR_STCS: exp_q.push_back(data[7:0]);
            INSTR_KEY: for (int i = 0; i < (8 << sc); i++) exp_q.push_back(key[8*i +: 8]);
            default: ;
        endcase
        return 1'b0;
    endfunction

    task automatic chk_seq(input string name);
        checks++;
        if (got_q.size() != lit_q.size()) begin
            failures++;
            $display("FAIL %s_len: got %0d required %0d", name, got_q.size(), lit_q.size());
        end else begin
            for (int i = 0; i < lit_q.size(); i++) chk(name, 32'(got_q[i]), 32'(lit_q[i]));
        end
    endtask

    task automatic send(input updi_instr_t ins, input logic [1:0] sa, sb, ptr, sc,
                        input logic [3:0] cs, input logic sib, input logic [23:0] addr,
                        input logic [15:0] data, input logic [127:0] key,
                        input bit ackok, input int ack_delay, input bit chk_bubble);
        bit err;
        bit ok;
        int pre_ack;
        int nbytes;
        int cyc;
        got_q.delete();
        err    = model_frame(ins, sa, sb, ptr, sc, cs, sib, addr, data, key, ackok, pre_ack);
        nbytes = exp_q.size();
        @(posedge clk);
        #1;
        cmd_instr = ins; cmd_size_a = sa; cmd_size_b = sb; cmd_ptr = ptr; cmd_size_c = sc;
        cmd_cs_addr = cs; cmd_sib = sib; cmd_addr = addr; cmd_data = data; cmd_key = key;
        cmd_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            tick();
            if (cmd_ready) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        chk("accept_timeout", 32'(ok), 32'd1);
        if (err) begin
            tick();
            chk("cmd_err_pulse", 32'(cmd_err), 32'd1);
            chk("cmd_err_busy", 32'(busy), 32'd0);
            tick();
            chk("cmd_err_clear", 32'(cmd_err), 32'd0);
            chk("cmd_err_no_bytes", 32'(got_q.size()), 32'd0);
            return;
        end
        if (ins == INSTR_STS) begin
            ok = 1'b0;
            for (int i = 0; i < 60 && !ok; i++) begin
                tick();
                if (got_q.size() >= pre_ack) ok = 1'b1;
            end
            chk("sts_addr_timeout", 32'(ok), 32'd1);
            for (int i = 0; i < ack_delay; i++) begin
                tick();
                chk("wait_ack_tx_valid", 32'(tx_valid), 32'd0);
                chk("wait_ack_busy", 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
            ack_valid = 1'b1;
            ack_ok    = ackok;
            @(posedge clk);
            #1;
            ack_valid = 1'b0;
            ack_ok    = 1'b0;
            if (!ackok) begin
                tick();
                chk("ack_err_pulse", 32'(ack_err), 32'd1);
                chk("ack_err_idle", 32'(busy), 32'd0);
                tick();
                chk("ack_err_clear", 32'(ack_err), 32'd0);
            end
        end
        ok  = 1'b0;
        cyc = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            tick();
            if (cmd_ready) ok = 1'b1;
            else cyc++;
        end
        chk("frame_end_timeout", 32'(ok), 32'd1);
        if (chk_bubble) chk("no_bubble_cycles", 32'(cyc), 32'(nbytes));
        chk("model_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [127:0] key8;
        logic [127:0] key16;
        int dummy;
        key8  = '0;
        key16 = '0;
        for (int i = 0; i < 8; i++)  key8[8*i +: 8]  = 8'(8'h10 + i);
        for (int i = 0; i < 16; i++) key16[8*i +: 8] = 8'(8'h80 + i);

        #1 rst_n = 1'b0;
        #2;
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'h00);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cmd_err", 32'(cmd_err), 32'd0);
        chk("rst_ack_err", 32'(ack_err), 32'd0);
        repeat (2) @(posedge clk);
        tick();
        rst_n = 1'b1;
        #1;
        chk("ready_before_edge", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", 32'(cmd_ready), 32'd1);

        lit_q = '{8'h55, 8'h04, 8'h34, 8'h12};
        send(INSTR_LDS, 2'd1, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'h001234, 16'h0, '0, 1'b1, 0, 1'b1);
        chk_seq("lds_word_addr");

        lit_q = '{8'h55, 8'h41, 8'h0F, 8'hEF, 8'hBE};
        send(INSTR_STS, 2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 1'b0, 24'h00000F, 16'hBEEF, '0, 1'b1, 5, 1'b0);
        chk_seq("sts_ack_ok");

        lit_q = '{8'h55, 8'h41, 8'h0F};
        send(INSTR_STS, 2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 1'b0, 24'h00000F, 16'hBEEF, '0, 1'b0, 2, 1'b0);
        chk_seq("sts_ack_bad");

        rand_ready = 1'b1;
        lit_q = '{8'h55, 8'hE0, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        send(INSTR_KEY, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0, key8, 1'b1, 0, 1'b0);
        chk_seq("key64_random_ready");
        send(INSTR_KEY, 2'd0, 2'd0, 2'd0, 2'd1, 4'd0, 1'b1, 24'h0, 16'h0, key16, 1'b1, 0, 1'b0);
        chk("key128_opcode", 32'(got_q[1]), 32'hE5);
        rand_ready = 1'b0;

        send(INSTR_LDS, 2'd3, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0, '0, 1'b1, 0, 1'b0);
        send(INSTR_KEY, 2'd0, 2'd0, 2'd0, 2'd2, 4'd0, 1'b0, 24'h0, 16'h0, '0, 1'b1, 0, 1'b0);
        send(INSTR_REPEAT, 2'd0, 2'd1, 2'd0, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0, '0, 1'b1, 0, 1'b0);
        send(INSTR_STS, 2'd0, 2'd2, 2'd0, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0, '0, 1'b1, 0, 1'b0);

        lit_q = '{8'h55, 8'hC3, 8'h08};
        send(INSTR_STCS, 2'd0, 2'd0, 2'd0, 2'd0, 4'd3, 1'b0, 24'h0, 16'h0008, '0, 1'b1, 0, 1'b1);
        chk_seq("stcs");

        lit_q = '{8'h55, 8'h65, 8'h5A, 8'hA5};
        send(INSTR_ST, 2'd1, 2'd0, 2'd1, 2'd0, 4'd0, 1'b0, 24'h0, 16'hA55A, '0, 1'b1, 0, 1'b1);
        chk_seq("st_word");

        lit_q = '{8'h55, 8'h28};
        send(INSTR_LD, 2'd0, 2'd0, 2'd2, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0, '0, 1'b1, 0, 1'b1);
        chk_seq("ld_ptr_inc");

        lit_q = '{8'h55, 8'hA0, 8'h07};
        send(INSTR_REPEAT, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0007, '0, 1'b1, 0, 1'b1);
        chk_seq("repeat");

        lit_q = '{8'h55, 8'h08, 8'hEF, 8'hCD, 8'hAB};
        send(INSTR_LDS, 2'd2, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'hABCDEF, 16'h0, '0, 1'b1, 0, 1'b1);
        chk_seq("lds_max_addr");

        // An ACK report while idle must be ignored.
        @(posedge clk);
        #1;
        ack_valid = 1'b1;
        @(posedge clk);
        #1;
        ack_valid = 1'b0;
        tick();
        chk("stray_ack_no_err", 32'(ack_err), 32'd0);
        chk("stray_ack_idle", 32'(busy), 32'd0);

        // Reset in the middle of an LDS address phase.
        got_q.delete();
        dummy = int'(model_frame(INSTR_LDS, 2'd2, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'h445566,
                                 16'h0, '0, 1'b1, dummy));
        @(posedge clk);
        #1;
        cmd_instr = INSTR_LDS; cmd_size_a = 2'd2; cmd_size_b = 2'd0; cmd_addr = 24'h445566;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        dummy = 0;
        for (int i = 0; i < 40 && got_q.size() < 3; i++) tick();
        chk("mid_frame_progress", 32'(got_q.size()), 32'd3);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(tx_data), 32'h00);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
        repeat (2) @(posedge clk);
        tick();
        rst_n = 1'b1;
        #1;
        chk("midrst_ready_low", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("midrst_ready_high", 32'(cmd_ready), 32'd1);
        chk("midrst_no_resume", 32'(tx_valid), 32'd0);

        lit_q = '{8'h55, 8'h80};
        send(INSTR_LDCS, 2'd0, 2'd0, 2'd0, 2'd0, 4'd0, 1'b0, 24'h0, 16'h0, '0, 1'b1, 0, 1'b1);
        chk_seq("ldcs_after_reset");

        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
